// File: rtl/rv32_dma.sv
// Word-granular DMA master on the picorv32 native memory bus: copies len words src->dst.
// Optional fill mode (constant word to dst) is compiled in with `define RV32_DMA_FILL_EN.
module rv32_dma #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] len,
`ifdef RV32_DMA_FILL_EN
  input  logic                 fill_en,
  input  logic [31:0]          fill_data,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 rv32_valid,
  input  logic                 rv32_ready,
  output logic [31:0]          rv32_addr,
  output logic [31:0]          rv32_wdata,
  output logic [3:0]           rv32_wstrb,
  input  logic [31:0]          rv32_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);
  localparam logic [AW-1:0] WORD_STEP = AW'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP,
    S_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [AW-1:0]        r_src, w_src_nxt;
  logic [AW-1:0]        r_dst, w_dst_nxt;
  logic [LEN_WIDTH-1:0] r_len, w_len_nxt;
  logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0]        r_buf, w_buf_nxt;
  logic                 r_fill, w_fill_nxt;

  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [AW-1:0]        r_addr, w_addr_nxt;
  logic [DW-1:0]        r_wdata, w_wdata_nxt;
  logic [SW-1:0]        r_wstrb, w_wstrb_nxt;

  logic                 w_fill_req;
  logic [DW-1:0]        w_fill_word;

`ifdef RV32_DMA_FILL_EN
  assign w_fill_req  = fill_en;
  assign w_fill_word = fill_data;
`else
  assign w_fill_req  = 1'b0;
  assign w_fill_word = '0;
`endif

  // Next-state, datapath and next request values (requests are launched from the next state)
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_buf_nxt   = r_buf;
    w_fill_nxt  = r_fill;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_src_nxt  = src_addr & WORD_MASK;
          w_dst_nxt  = dst_addr & WORD_MASK;
          w_len_nxt  = len;
          w_cnt_nxt  = '0;
          w_fill_nxt = w_fill_req;
          if (w_fill_req) begin
            w_buf_nxt = w_fill_word;
          end
          if (len == '0) begin
            w_state_nxt = S_DONE;
          end else if (w_fill_req) begin
            w_state_nxt = S_WR;
          end else begin
            w_state_nxt = S_RD;
          end
        end
      end
      S_RD: begin
        if (rv32_ready) begin
          w_buf_nxt   = rv32_rdata;
          w_src_nxt   = r_src + WORD_STEP;
          w_state_nxt = S_RD_GAP;
        end
      end
      S_RD_GAP: w_state_nxt = S_WR;
      S_WR: begin
        if (rv32_ready) begin
          w_dst_nxt   = r_dst + WORD_STEP;
          w_cnt_nxt   = r_cnt + LEN_WIDTH'(1);
          w_state_nxt = S_WR_GAP;
        end
      end
      S_WR_GAP: begin
        if (r_cnt == r_len) begin
          w_state_nxt = S_DONE;
        end else if (r_fill) begin
          w_state_nxt = S_WR;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Address/data/strobe only change on entry to a request, so they hold through wait states
    w_valid_nxt = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_wstrb_nxt = r_wstrb;
    if (w_state_nxt == S_RD) begin
      w_addr_nxt  = w_src_nxt;
      w_wstrb_nxt = '0;
    end else if (w_state_nxt == S_WR) begin
      w_addr_nxt  = w_dst_nxt;
      w_wdata_nxt = w_buf_nxt;
      w_wstrb_nxt = '1;
    end
    w_busy_nxt = (w_state_nxt == S_RD) || (w_state_nxt == S_RD_GAP) ||
                 (w_state_nxt == S_WR) || (w_state_nxt == S_WR_GAP);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_fill  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
      r_fill  <= w_fill_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_wstrb <= w_wstrb_nxt;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rv32_valid = r_valid;
  assign rv32_addr  = r_addr;
  assign rv32_wdata = r_wdata;
  assign rv32_wstrb = r_wstrb;

endmodule

// File: tb/tb_rv32_dma.sv
// Scoreboard bench for rv32_dma: expected bus transactions and done cycles are queued at
// stimulus time and checked by a negedge monitor against a wait-state-configurable memory.
module tb_rv32_dma;

  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [LW-1:0] len;
  logic          fill_en;
  logic [31:0]   fill_data;
  logic          busy;
  logic          done;
  logic          rv32_valid;
  logic          rv32_ready;
  logic [31:0]   rv32_addr;
  logic [31:0]   rv32_wdata;
  logic [3:0]    rv32_wstrb;
  logic [31:0]   rv32_rdata;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t q_exp[$];
  int   q_done[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   wait_n  = 0;
  int   r_wcnt  = 0;
  logic [31:0] mem [0:1023];

  rv32_dma #(.LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
`ifdef RV32_DMA_FILL_EN
    .fill_en    (fill_en),
    .fill_data  (fill_data),
`endif
    .busy       (busy),
    .done       (done),
    .rv32_valid (rv32_valid),
    .rv32_ready (rv32_ready),
    .rv32_addr  (rv32_addr),
    .rv32_wdata (rv32_wdata),
    .rv32_wstrb (rv32_wstrb),
    .rv32_rdata (rv32_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: ready after wait_n wait cycles; memory preloaded while reset is high
  assign rv32_ready = rv32_valid && (r_wcnt >= wait_n);
  assign rv32_rdata = mem[rv32_addr[11:2]];

  always @(posedge clk) begin
    if (rv32_valid && !rv32_ready) r_wcnt <= r_wcnt + 1;
    else                           r_wcnt <= 0;
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[64]   <= 32'h0000_000A;
      mem[65]   <= 32'h0000_000B;
      mem[66]   <= 32'h0000_000C;
      mem[0]    <= 32'h3333_4444;
      mem[1023] <= 32'h1111_2222;
    end else if (rv32_valid && rv32_ready && rv32_wstrb == 4'hF) begin
      mem[rv32_addr[11:2]] <= rv32_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic exp_rd(input logic [31:0] a);
    q_exp.push_back({1'b0, a, 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    q_exp.push_back({1'b1, a, d});
  endtask

  // Pulse start for one cycle; e = cycle index right after the sampling edge (spec T+1)
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [LW-1:0] l,
                          input logic fe, input logic [31:0] fd, output int e);
    @(negedge clk);
    src_addr  = s;
    dst_addr  = d;
    len       = l;
    fill_en   = fe;
    fill_data = fd;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e     = cyc;
    start = 1'b0;
    if (l != '0) begin
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_valid", 32'(rv32_valid), 32'd1);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (q_done.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (q_done.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: %0d done pulses still pending after %0d cycles", q_done.size(), k);
      q_done.delete();
    end
    @(negedge clk);
    chk("txn_left", 32'(q_exp.size()), 32'd0);
    q_exp.delete();
  endtask

  // Monitor: handshakes, request stability, inter-request gap, done timing
  bit          prev_hs   = 1'b0;
  bit          prev2_hs  = 1'b0;
  bit          prev_pend = 1'b0;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wstrb;

  always @(negedge clk) begin : mon
    txn_t t;
    int   d;
    bit   hs;
    hs = rv32_valid && rv32_ready;
    if (prev_hs)  chk("gap_valid_low", 32'(rv32_valid), 32'd0);
    if (prev2_hs) chk("gap_one_cycle", 32'(rv32_valid), 32'(busy));
    if (rv32_valid && prev_pend) begin
      chk("stable_addr", rv32_addr, p_addr);
      chk("stable_wdata", rv32_wdata, p_wdata);
      chk("stable_wstrb", 32'(rv32_wstrb), 32'(p_wstrb));
    end
    if (hs) begin
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_txn: addr %h wstrb %h with nothing expected", rv32_addr, rv32_wstrb);
      end else begin
        t = q_exp.pop_front();
        chk("txn_addr", rv32_addr, t.addr);
        chk("txn_wstrb", 32'(rv32_wstrb), t.we ? 32'hF : 32'h0);
        if (t.we) chk("txn_wdata", rv32_wdata, t.data);
      end
    end
    if (done) begin
      if (q_done.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done pulse at cycle %0d with none expected", cyc);
      end else begin
        d = q_done.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d));
        chk("done_busy", 32'(busy), 32'd0);
      end
    end
    prev_pend = rv32_valid && !rv32_ready;
    p_addr    = rv32_addr;
    p_wdata   = rv32_wdata;
    p_wstrb   = rv32_wstrb;
    prev2_hs  = prev_hs;
    prev_hs   = hs;
  end

  initial begin
    int e;
    int k;
    reset     = 1'b1;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    len       = '0;
    fill_en   = 1'b0;
    fill_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rv32_valid), 32'd0);
    chk("rst_addr", rv32_addr, 32'd0);
    chk("rst_wdata", rv32_wdata, 32'd0);
    chk("rst_wstrb", 32'(rv32_wstrb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Copy 3 words, zero-wait: done 12 cycles after T+1
    exp_rd(32'h100); exp_wr(32'h200, 32'hA);
    exp_rd(32'h104); exp_wr(32'h204, 32'hB);
    exp_rd(32'h108); exp_wr(32'h208, 32'hC);
    do_start(32'h100, 32'h200, LW'(3), 1'b0, 32'h0, e);
    q_done.push_back(e + 12);
    wait_done();
    chk("mem_208", mem[130], 32'hC);

    // len = 0: done at T+1, no request, no busy
    do_start(32'h100, 32'h200, LW'(0), 1'b0, 32'h0, e);
    q_done.push_back(e);
    chk("len0_valid", 32'(rv32_valid), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    wait_done();

    // Backpressure: 5 wait cycles on read and on write
    wait_n = 5;
    exp_rd(32'h108); exp_wr(32'h600, 32'hC);
    do_start(32'h108, 32'h600, LW'(1), 1'b0, 32'h0, e);
    q_done.push_back(e + 14);
    wait_done();
    wait_n = 0;

    // Source pointer wraps past the top of the address space
    exp_rd(32'hFFFF_FFFC); exp_wr(32'h300, 32'h1111_2222);
    exp_rd(32'h0000_0000); exp_wr(32'h304, 32'h3333_4444);
    do_start(32'hFFFF_FFFC, 32'h300, LW'(2), 1'b0, 32'h0, e);
    q_done.push_back(e + 8);
    wait_done();

    // Misaligned addresses, then an immediate restart in the first IDLE cycle (H+3)
    exp_rd(32'h100); exp_wr(32'h208, 32'hA);
    do_start(32'h103, 32'h20B, LW'(1), 1'b0, 32'h0, e);
    q_done.push_back(e + 4);
    repeat (5) @(negedge clk);
    exp_rd(32'h104); exp_wr(32'h400, 32'hB);
    do_start(32'h104, 32'h400, LW'(1), 1'b0, 32'h0, e);
    q_done.push_back(e + 4);
    // start during the transfer must be ignored
    @(negedge clk);
    src_addr = 32'h700;
    dst_addr = 32'h800;
    len      = LW'(5);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset while a write is pending
    wait_n = 3;
    exp_rd(32'h100);
    do_start(32'h100, 32'h500, LW'(2), 1'b0, 32'h0, e);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(rv32_valid && rv32_wstrb == 4'hF) && k < 50);
    chk("rst_wr_reached", 32'(rv32_valid && rv32_wstrb == 4'hF), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(rv32_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_addr", rv32_addr, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    wait_n = 0;
    repeat (3) @(negedge clk);
    chk("midrst_q_empty", 32'(q_exp.size()), 32'd0);
    exp_rd(32'h104); exp_wr(32'h504, 32'hB);
    do_start(32'h104, 32'h504, LW'(1), 1'b0, 32'h0, e);
    q_done.push_back(e + 4);
    wait_done();

`ifdef RV32_DMA_FILL_EN
    // Fill: four writes of a constant word, 2 cycles per word
    exp_wr(32'h40, 32'hDEAD_BEEF); exp_wr(32'h44, 32'hDEAD_BEEF);
    exp_wr(32'h48, 32'hDEAD_BEEF); exp_wr(32'h4C, 32'hDEAD_BEEF);
    do_start(32'h900, 32'h40, LW'(4), 1'b1, 32'hDEAD_BEEF, e);
    q_done.push_back(e + 8);
    wait_done();
    fill_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
